// File: rtl/cl_serial.sv
// Bit-serial 3-bit-select logic cell: evaluates one of eight bitwise ops SLICE bits per clock.
// Define CL_STATUS_EN to add the registered out_zero / out_parity status outputs.
module cl_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
`ifdef CL_STATUS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_param
      $error("cl_serial: SLICE must be positive and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [SLICE-1:0]  slice;
`ifdef CL_STATUS_EN
  logic              zero_q, zero_d;
  logic              parity_q, parity_d;
`endif

  function automatic logic [SLICE-1:0] applyOp(input logic [2:0] op,
                                               input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~a;
      3'b100:  return ~(a & b);
      3'b101:  return ~(a | b);
      3'b110:  return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
`ifdef CL_STATUS_EN
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
`ifdef CL_STATUS_EN
      zero_q   <= zero_d;
      parity_q <= parity_d;
`endif
    end
  end

  // Result slices enter from the MSB side, so after N shifts the LSB slice sits at the bottom.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    slice     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef CL_STATUS_EN
    zero_d    = zero_q;
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_s;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        slice                  = applyOp(op_q, a_q[SLICE-1:0], b_q[SLICE-1:0]);
        acc_d                  = acc_q >> SLICE;
        acc_d[WIDTH-1 -: SLICE] = slice;
        a_d                    = a_q >> SLICE;
        b_d                    = b_q >> SLICE;
        cnt_d                  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          y_d      = acc_d;
`ifdef CL_STATUS_EN
          zero_d   = (acc_d == '0);
          parity_d = ^acc_d;
`endif
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_y = y_q;
`ifdef CL_STATUS_EN
  assign out_zero   = zero_q;
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_cl_serial.sv
// Self-checking bench for cl_serial: word-level reference model plus directed literal checks.
// Also exercises a WIDTH=16, SLICE=4 instance; status checks active when CL_STATUS_EN is defined.
module tb_cl_serial;

  localparam int MN = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic [2:0]  in_s;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_y;
  logic        in2Valid, in2Ready, out2Valid, out2Ready;
  logic [15:0] in2A, in2B, out2Y;
  logic [2:0]  in2S;
`ifdef CL_STATUS_EN
  logic        out_zero, out_parity, out2Zero, out2Parity;
`endif

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  int         mLeft = 0;
  bit         mDone = 0;
  logic [7:0] mY = '0, mPend = '0;
  bit         mZ = 0, mP = 0;

  always #5 clk = ~clk;

  cl_serial #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y)
`ifdef CL_STATUS_EN
    , .out_zero(out_zero), .out_parity(out_parity)
`endif
  );

  cl_serial #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in2Valid), .in_ready(in2Ready),
    .in_a(in2A), .in_b(in2B), .in_s(in2S), .out_valid(out2Valid),
    .out_ready(out2Ready), .out_y(out2Y)
`ifdef CL_STATUS_EN
    , .out_zero(out2Zero), .out_parity(out2Parity)
`endif
  );

  function automatic logic [7:0] refOp(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] s);
    case (s)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted op produces its whole-word result MN edges later.
  always @(posedge clk) begin
    if (!reset_n) begin
      mLeft = 0; mDone = 0; mY = '0; mZ = 0; mP = 0;
    end else if (mDone) begin
      if (out_ready) mDone = 0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) begin
        mDone = 1; mY = mPend; mZ = (mPend == 8'h00); mP = ^mPend;
      end
    end else if (in_valid) begin
      mLeft = MN;
      mPend = refOp(in_a, in_b, in_s);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmp_in_ready", 32'(in_ready), 32'(!mDone && mLeft == 0));
      checkOutput("cmp_out_valid", 32'(out_valid), 32'(mDone));
      checkOutput("cmp_out_y", 32'(out_y), 32'(mY));
`ifdef CL_STATUS_EN
      checkOutput("cmp_out_zero", 32'(out_zero), 32'(mZ));
      checkOutput("cmp_out_parity", 32'(out_parity), 32'(mP));
`endif
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_s = s;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] s, input logic [7:0] expY);
    int edges;
    bit seen;
    applyStimulus(a, b, s);
    edges = 0; seen = 0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = out_valid;
    end
    checkOutput({name, "_latency"}, 32'(edges), 32'd4);
    checkOutput(name, 32'(out_y), 32'(expY));
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int edges;
    bit seen;
    reset_n = 1'b0; in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_s = 3'b000;
    out_ready = 1'b0;
    in2Valid = 1'b0; in2A = '0; in2B = '0; in2S = '0; out2Ready = 1'b1;
    @(posedge clk);
    checkEn = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_y", 32'(out_y), 32'h00);
    reset_n = 1'b1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_nothing_captured", 32'(out_valid), 32'd0);

    runOp("and",  8'hF0, 8'h3C, 3'b000, 8'h30); releaseResult();
    runOp("or",   8'hF0, 8'h3C, 3'b001, 8'hFC); releaseResult();
    runOp("xor",  8'hF0, 8'h3C, 3'b010, 8'hCC); releaseResult();
    runOp("nand", 8'hF0, 8'h3C, 3'b100, 8'hCF); releaseResult();
    runOp("xnor", 8'hF0, 8'h3C, 3'b110, 8'h33); releaseResult();
    runOp("not",  8'h0F, 8'h00, 3'b011, 8'hF0); releaseResult();
    runOp("pass", 8'hFF, 8'hA5, 3'b111, 8'hA5); releaseResult();
    runOp("nor",  8'h00, 8'h00, 3'b101, 8'hFF); releaseResult();

    // Backpressure: result must hold while new operands are offered and ignored.
    runOp("bp", 8'h12, 8'h34, 3'b010, 8'h26);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_s = 3'b000;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_out_y", 32'(out_y), 32'h26);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    releaseResult();
    repeat (6) @(negedge clk);
    checkOutput("bp_no_capture", 32'(out_valid), 32'd0);

    // Reset sampled on the second BUSY edge discards the op.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hC3; in_b = 8'h3C; in_s = 3'b001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_out_y", 32'(out_y), 32'h00);
      @(negedge clk);
    end
    runOp("fresh", 8'hAA, 8'h0F, 3'b000, 8'h0A); releaseResult();

`ifdef CL_STATUS_EN
    runOp("st_xor", 8'h55, 8'h55, 3'b010, 8'h00);
    checkOutput("st_xor_zero", 32'(out_zero), 32'd1);
    checkOutput("st_xor_parity", 32'(out_parity), 32'd0);
    releaseResult();
    runOp("st_or", 8'h55, 8'h55, 3'b001, 8'h55);
    checkOutput("st_or_zero", 32'(out_zero), 32'd0);
    checkOutput("st_or_parity", 32'(out_parity), 32'd0);
    releaseResult();
    runOp("st_par", 8'h01, 8'h00, 3'b001, 8'h01);
    checkOutput("st_par_zero", 32'(out_zero), 32'd0);
    checkOutput("st_par_parity", 32'(out_parity), 32'd1);
    releaseResult();
`endif

    // Wide instance: N = 16/4 = 4, so latency stays 4 edges.
    @(negedge clk);
    in2Valid = 1'b1; in2A = 16'hF0F0; in2B = 16'h3C3C; in2S = 3'b000;
    @(posedge clk);
    @(negedge clk);
    in2Valid = 1'b0;
    edges = 0; seen = 0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = out2Valid;
    end
    checkOutput("w16_latency", 32'(edges), 32'd4);
    checkOutput("w16_out_y", 32'(out2Y), 32'h3030);
`ifdef CL_STATUS_EN
    checkOutput("w16_zero", 32'(out2Zero), 32'd0);
    checkOutput("w16_parity", 32'(out2Parity), 32'd0);
`endif
    @(negedge clk);
    checkOutput("w16_idle", 32'(in2Ready), 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cl_serial.md
Name: cl_serial

Overview:
- Parametrised, sequential successor to the 2-bit-select logic cell.
- Takes two WIDTH-bit operands and a 3-bit operation code.
- Evaluates the operation bit-serially, SLICE bits per clock, LSB slice first.
- Returns the registered result over a valid/ready handshake; sits between an operand producer and a result consumer in the datapath.

Parameters:
WIDTH, 8, operand/result width in bits
SLICE, 2, bits processed per clock; must divide WIDTH exactly

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept operands
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_s  input  3  operation select
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_y  output  WIDTH  result

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous, active-low (reset_n sampled on rising clk).
  - Reset state: IDLE; in_ready=1, out_valid=0, out_y=0; all internal shift registers, counter and latched op cleared.
- Op codes (bitwise, per bit):
  - 000 a AND b; 001 a OR b; 010 a XOR b; 011 NOT a
  - 100 NAND; 101 NOR; 110 XNOR; 111 pass b
- Parameter check: WIDTH % SLICE != 0 -> elaboration-time error. Define N = WIDTH/SLICE.
- FSM states IDLE, BUSY, DONE:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid=1 at an edge: capture in_a, in_b, in_s; clear slice counter; go BUSY.
    - in_a/in_b/in_s are ignored at every other time.
  - BUSY:
    - in_ready=0.
    - Each edge: apply the latched op to the low SLICE bits of the a/b shift registers.
    - Shift the resulting slice into the result register from the MSB side; shift a/b right by SLICE; increment counter.
    - After the N-th BUSY edge: result complete, out_y loaded, go DONE.
  - DONE:
    - out_valid=1, out_y stable, in_ready=0.
    - Hold indefinitely while out_ready=0.
    - On out_ready=1 at an edge: go IDLE; out_valid drops; in_ready rises the following cycle.
    - No same-cycle accept of new operands.
- Latency: acceptance at edge k -> out_valid high after edge k+N (N=4 at defaults). Throughput: one operation per N+2 cycles minimum.
- out_y holds its last result through IDLE and BUSY; it changes only when loaded on entry to DONE.
- in_s outside 000..111: not possible (3 bits fully decoded).
- Reset mid-operation (BUSY or DONE): operation discarded, no out_valid pulse, return to reset state.
- Simultaneous in_valid and reset_n=0: reset wins, nothing captured.
- out_ready asserted outside DONE: no effect.

Optional Feature:
- Macro: CL_STATUS_EN.
- Defined:
  - Two extra output ports after out_y: out_zero (1) = (result == 0), out_parity (1) = XOR-reduce of result.
  - Both registered alongside out_y, valid with out_valid, reset to 0, held like out_y.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: reset_n=0 for 2 edges with in_valid=1 -> in_ready=1, out_valid=0, out_y=8'h00; nothing captured.
- Basic ops (defaults): a=8'hF0, b=8'h3C, s=000 -> out_valid exactly 4 edges after accept, out_y=8'h30. Same operands:
  - s=001 -> 8'hFC
  - s=010 -> 8'hCC
  - s=100 -> 8'hCF
  - s=110 -> 8'h33
- Unary/pass: a=8'h0F, s=011 -> 8'hF0; b=8'hA5, s=111 -> 8'hA5; s=101 with a=8'h00, b=8'h00 -> 8'hFF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> out_valid=1 and out_y unchanged throughout, in_ready=0, new operands ignored. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: pull reset_n=0 on the 2nd BUSY edge -> out_valid never asserts, in_ready=1 after reset, out_y=8'h00. A fresh op (a=8'hAA, b=8'h0F, s=000) then yields 8'h0A.
- CL_STATUS_EN: a=b=8'h55, s=010 -> out_y=0, out_zero=1, out_parity=0; s=001 -> 8'h55, zero=0, parity=0; a=8'h01, b=8'h00, s=001 -> parity=1. Repeat one case with WIDTH=16, SLICE=4 -> latency 4 edges.
